// File: rtl/alu_issue_ctrl.sv
// Issues register-to-register instructions to a combinational ALU on a fixed
// three-cycle schedule. It holds a 4-entry register file and writes each result back.
//
// state | meaning
// IDLE  | waiting for an instruction; direct loads allowed
// EXEC  | operands and opcode presented to the ALU; result captured at the edge
// WB    | wb_valid pulse cycle; returns to IDLE
module alu_issue_ctrl #(
    parameter int word_size = 8,
    parameter int num_regs  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           instr_op,
    input  logic [1:0]           instr_rd,
    input  logic [1:0]           instr_rs1,
    input  logic [1:0]           instr_rs2,
    input  logic                 ld_en,
    input  logic [1:0]           ld_addr,
    input  logic [word_size-1:0] ld_data,
    output logic [3:0]           alu_sel,
    output logic [word_size-1:0] alu_data_1,
    output logic [word_size-1:0] alu_data_2,
    input  logic [word_size-1:0] alu_out,
    input  logic                 alu_zero_flag,
    output logic                 wb_valid,
    output logic [word_size-1:0] wb_data,
    output logic [1:0]           wb_addr,
    output logic                 z_flag,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t               state, state_next;
    logic                 accept, do_load, do_wb;
    logic [1:0]           rd;
    logic [word_size-1:0] rf [num_regs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A load in IDLE takes priority over an instruction in the same cycle.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        do_load    = 1'b0;
        do_wb      = 1'b0;
        case (state)
            IDLE: begin
                do_load = ld_en;
                accept  = instr_valid && !ld_en;
                if (accept) state_next = EXEC;
            end
            EXEC: begin
                do_wb      = 1'b1;
                state_next = WB;
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign instr_ready = (state == IDLE) && !ld_en;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < num_regs; i++) rf[i] <= '0;
        end else if (do_wb) begin
            rf[rd] <= alu_out;
        end else if (do_load) begin
            rf[ld_addr] <= ld_data;
        end
    end

    // Operands are read only at the accept edge, so rd aliasing a source sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_sel    <= '0;
            alu_data_1 <= '0;
            alu_data_2 <= '0;
            rd         <= '0;
        end else if (accept) begin
            alu_sel    <= instr_op;
            alu_data_1 <= rf[instr_rs1];
            alu_data_2 <= rf[instr_rs2];
            rd         <= instr_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_addr  <= '0;
            z_flag   <= 1'b0;
        end else begin
            wb_valid <= do_wb;
            if (do_wb) begin
                wb_data <= alu_out;
                wb_addr <= rd;
                z_flag  <= alu_zero_flag;
            end
        end
    end

endmodule
